gate_access_arbiter: RTL
========================

// Module: gate_access_arbiter
// PURPOSE
//   Shares the single vehicle gate among 4 access requesters (lane/credential sources).
//   Picks one active request round-robin and drives one-hot grant + 2-bit grant code
//   (code = index of the one-hot bit: 0001->00, 0010->01, 0100->10, 1000->11).
//   Sequences the gate for the granted request: open -> wait for vehicle pass -> close.
//   Sits between credential/request logic and the gate actuator/sensor interface.
// PARAMETERS
//   OPEN_CYCLES   3..  default 50   cycles gate_open_cmd is held (min 1)
//   PASS_TIMEOUT  default 200       max cycles in WAIT_PASS before abort (min 1)
//   CLOSE_CYCLES  default 50        cycles gate_close_cmd is held (min 1)
//   CNT_W         default 8         width of pass_count
// PORTS
//   clk              in   1      system clock, rising edge
//   rst_n            in   1      asynchronous, active-low reset
//   req              in   4      level requests, bit i = requester i
//   vehicle_present  in   1      gate-line sensor, 1 = vehicle in gate (synchronous to clk)
//   grant            out  4      one-hot grant, 0000 when idle
//   grant_code       out  2      encoded index of grant, 00 when idle
//   grant_valid      out  1      1 while a transaction owns the gate
//   gate_open_cmd    out  1      1 during OPENING
//   gate_close_cmd   out  1      1 during CLOSING
//   busy             out  1      1 whenever state != IDLE
//   timeout_err      out  1      1-cycle pulse on pass timeout
//   pass_count       out  CNT_W  completed vehicle passes, saturating
// BEHAVIOUR
//   Reset: clock and reset are as fixed above -- one clock (clk); reset is asynchronous and
//     active-low (rst_n). rst_n=0 forces state IDLE, all outputs 0, pass_count 0, timers 0,
//     RR pointer=3 (so requester 0 has top priority first). Applies mid-transaction too: gate
//     cmds drop immediately.
//   FSM: IDLE -> OPENING -> WAIT_PASS -> CLOSING -> IDLE. All outputs registered.
//   IDLE: if req!=0 at edge k, winner = first set bit searching ptr+1, ptr+2.. (mod 4);
//     after edge k: state=OPENING, grant/grant_code/grant_valid set, ptr=winner. req=0: stay.
//   Requests sampled only in IDLE; req changes while busy are ignored (no queuing).
//   OPENING: gate_open_cmd=1 for exactly OPEN_CYCLES cycles, then WAIT_PASS.
//   WAIT_PASS: sets seen flag when vehicle_present=1; pass complete when vehicle_present=0
//     with seen=1 -> pass_count+1 (hold at 2^CNT_W-1), go CLOSING.
//     If PASS_TIMEOUT cycles elapse without completion -> timeout_err=1 for one cycle
//     (the cycle after the last WAIT_PASS cycle, i.e. first CLOSING cycle), go CLOSING, no count.
//     Completion and timeout on the same cycle: completion wins, no timeout_err.
//   CLOSING: gate_close_cmd=1 for exactly CLOSE_CYCLES cycles; vehicle_present ignored;
//     then IDLE with grant=0000, grant_code=00, grant_valid=0, busy=0.
//   grant, grant_code, grant_valid stable for whole transaction (OPENING..CLOSING).
//   gate_open_cmd and gate_close_cmd never 1 together. New arbitration possible the
//     cycle after returning to IDLE (one IDLE cycle minimum between transactions).
// TESTING (OPEN_CYCLES=3, PASS_TIMEOUT=10, CLOSE_CYCLES=2, CNT_W=2)
//   Reset: rst_n=0 with req=1111 -> all outputs 0, pass_count 0; after release, grant 0001.
//   req=0101 held -> 1st grant 0001/code 00; next transaction grant 0100/code 10.
//   req=1111 held -> grant codes 00,01,10,11,00 in order over 5 transactions.
//   Pass: vehicle_present 1 for 2 cycles then 0 in WAIT_PASS -> pass_count 1, close 2 cycles,
//     busy low; 4 passes -> pass_count stays 3 (saturate).
//   Timeout: vehicle_present=0 -> exactly one timeout_err pulse after 10 WAIT_PASS cycles,
//     pass_count unchanged; falling edge on 10th cycle -> count+1, no timeout_err.
//   rst_n=0 during OPENING -> gate_open_cmd/grant drop same cycle; req=0011 then grants 0001.

Source files
------------

// File: rtl/gate_access_if.sv
// gate_access_if
//   Bundles the arbiter's request/sensor inputs and its grant/actuator outputs.
//   master : the requester/sensor side (drives req and vehicle_present)
//   slave  : the arbiter (drives grant, grant_code, grant_valid, gate_open_cmd,
//            gate_close_cmd, busy, timeout_err, pass_count)
//   CNT_W sets the width of pass_count and must match the arbiter's CNT_W.
interface gate_access_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic             vehicle_present;
    logic [3:0]       grant;
    logic [1:0]       grant_code;
    logic             grant_valid;
    logic             gate_open_cmd;
    logic             gate_close_cmd;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] pass_count;

    modport master (
        output req, vehicle_present,
        input  grant, grant_code, grant_valid, gate_open_cmd, gate_close_cmd,
               busy, timeout_err, pass_count
    );

    modport slave (
        input  req, vehicle_present,
        output grant, grant_code, grant_valid, gate_open_cmd, gate_close_cmd,
               busy, timeout_err, pass_count
    );
endinterface

// File: rtl/gate_access_arbiter.sv
// gate_access_arbiter
//   Shares one vehicle gate among 4 requesters. A round-robin arbiter picks one
//   active request while idle, then the gate is sequenced open -> wait for the
//   vehicle to pass (or time out) -> close, after which the gate is released.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : gate_access_if.slave
//            req[3:0] level requests, vehicle_present gate-line sensor (inputs)
//            grant one-hot, grant_code index, grant_valid, gate_open_cmd,
//            gate_close_cmd, busy, timeout_err pulse, pass_count (outputs)
//   All outputs are registered.
module gate_access_arbiter #(
    parameter int OPEN_CYCLES  = 50,
    parameter int PASS_TIMEOUT = 200,
    parameter int CLOSE_CYCLES = 50,
    parameter int CNT_W        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    gate_access_if.slave  bus
);

    // One shared timer serves every timed state, so size it for the longest.
    localparam int T_MAX0 = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
    localparam int T_MAX  = (T_MAX0 > CLOSE_CYCLES) ? T_MAX0 : CLOSE_CYCLES;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] PASS_LAST  = TW'(PASS_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OPENING   = 2'd1,
        WAIT_PASS = 2'd2,
        CLOSING   = 2'd3
    } state_t;

    state_t           state_reg;
    logic [1:0]       ptr_reg;
    logic [3:0]       grant_reg;
    logic [1:0]       code_reg;
    logic             valid_reg;
    logic             open_reg;
    logic             close_reg;
    logic             busy_reg;
    logic             terr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [TW-1:0]    timer_reg;
    logic             seen_reg;

    logic [1:0]       win_code;
    logic [3:0]       win_onehot;
    logic [1:0]       cand;

    // Round-robin search from ptr+1 upward (mod 4). Offsets are visited from
    // farthest to nearest so the nearest set request is the last assignment.
    // Offset 4 wraps back to ptr itself, which becomes lowest priority.
    always_comb begin
        win_code = ptr_reg;
        cand     = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_reg + 2'(k + 1);
            if (bus.req[cand]) begin
                win_code = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_code == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd3;
            grant_reg <= '0;
            code_reg  <= '0;
            valid_reg <= 1'b0;
            open_reg  <= 1'b0;
            close_reg <= 1'b0;
            busy_reg  <= 1'b0;
            terr_reg  <= 1'b0;
            count_reg <= '0;
            timer_reg <= '0;
            seen_reg  <= 1'b0;
        end else begin
            terr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req != 4'b0000) begin
                        state_reg <= OPENING;
                        grant_reg <= win_onehot;
                        code_reg  <= win_code;
                        valid_reg <= 1'b1;
                        ptr_reg   <= win_code;
                        open_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                        timer_reg <= '0;
                    end
                end

                OPENING: begin
                    if (timer_reg == OPEN_LAST) begin
                        state_reg <= WAIT_PASS;
                        open_reg  <= 1'b0;
                        timer_reg <= '0;
                        seen_reg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                WAIT_PASS: begin
                    // Completion is tested first so it beats a timeout on the
                    // same cycle.
                    if (seen_reg && !bus.vehicle_present) begin
                        if (count_reg != {CNT_W{1'b1}}) begin
                            count_reg <= count_reg + 1'b1;
                        end
                        state_reg <= CLOSING;
                        close_reg <= 1'b1;
                        timer_reg <= '0;
                    end else if (timer_reg == PASS_LAST) begin
                        terr_reg  <= 1'b1;
                        state_reg <= CLOSING;
                        close_reg <= 1'b1;
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                        if (bus.vehicle_present) begin
                            seen_reg <= 1'b1;
                        end
                    end
                end

                CLOSING: begin
                    if (timer_reg == CLOSE_LAST) begin
                        state_reg <= IDLE;
                        close_reg <= 1'b0;
                        grant_reg <= '0;
                        code_reg  <= '0;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant          = grant_reg;
    assign bus.grant_code     = code_reg;
    assign bus.grant_valid    = valid_reg;
    assign bus.gate_open_cmd  = open_reg;
    assign bus.gate_close_cmd = close_reg;
    assign bus.busy           = busy_reg;
    assign bus.timeout_err    = terr_reg;
    assign bus.pass_count     = count_reg;

endmodule
